// File: rtl/conv_window_buffer_pkg.sv
// Shared constants and the flattened-window indexing helper for the 5x5 window path.
package conv_window_buffer_pkg;

   localparam int BITWIDTH_DEF = 32;
   localparam int KSIZE        = 5;

   // LSB of element [i][j] in the flattened window bus
   function automatic int win_lsb(input int i, input int j, input int bw);
      return (i * KSIZE + j) * bw;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One feature-map row of pixel storage: combinational read and write at the same column address.
// Latency: read is combinational, write lands on the next clk edge.
// Backpressure: none; wr_en is the parent's accept strobe.
module conv_line_buffer
   import conv_window_buffer_pkg::*;
#(
   parameter int bitwidth = BITWIDTH_DEF,
   parameter int MAP_W    = 32,
   localparam int AW      = $clog2(MAP_W)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [AW-1:0]       addr,
   input  logic [bitwidth-1:0] wr_dat,
   output logic [bitwidth-1:0] rd_dat
);

   logic [bitwidth-1:0] mem [MAP_W];

   // Contents are don't-care until rewritten, so the array is never reset
   assign rd_dat = mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_dat;
      end
   end

endmodule

// File: rtl/conv_window_buffer.sv
// Raster pixel stream to 5x5 stride-1 windows for convolution_point.
// Latency: one cycle from the accept of a window's newest pixel to out_valid.
// Backpressure: single output register, no skid; in_ready drops while a window is stalled.
module conv_window_buffer
   import conv_window_buffer_pkg::*;
#(
   parameter int bitwidth = BITWIDTH_DEF,
   parameter int MAP_W    = 32,
   parameter int MAP_H    = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [bitwidth-1:0]               in_pixel,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [KSIZE*KSIZE*bitwidth-1:0]   out_window,
   output logic [$clog2(MAP_H)-1:0]          out_row,
   output logic [$clog2(MAP_W)-1:0]          out_col,
   output logic                              frame_done
);

   localparam int RW = $clog2(MAP_H);
   localparam int CW = $clog2(MAP_W);

   localparam logic [RW-1:0] ROW_LAST     = RW'(MAP_H - 1);
   localparam logic [CW-1:0] COL_LAST     = CW'(MAP_W - 1);
   localparam logic [RW-1:0] ROW_FIRST    = RW'(KSIZE - 1);
   localparam logic [CW-1:0] COL_FIRST    = CW'(KSIZE - 1);
   localparam logic [RW-1:0] ROW_WIN_LAST = RW'(MAP_H - KSIZE);
   localparam logic [CW-1:0] COL_WIN_LAST = CW'(MAP_W - KSIZE);

   logic [RW-1:0]       row;
   logic [CW-1:0]       col;
   logic                accept;
   logic                emit;
   logic [bitwidth-1:0] win   [KSIZE][KSIZE];
   logic [bitwidth-1:0] lb_rd [KSIZE-1];

   assign in_ready   = !rst && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign emit       = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
   assign frame_done = out_valid && out_ready &&
                       (out_row == ROW_WIN_LAST) && (out_col == COL_WIN_LAST);

   // Rows cascade upward: each buffer takes the next-younger row, the youngest takes in_pixel
   for (genvar k = 0; k < KSIZE - 1; k++) begin : g_lb
      logic [bitwidth-1:0] wr_dat;
      if (k == KSIZE - 2) begin : g_newest
         assign wr_dat = in_pixel;
      end else begin : g_older
         assign wr_dat = lb_rd[k+1];
      end
      conv_line_buffer #(
         .bitwidth (bitwidth),
         .MAP_W    (MAP_W)
      ) u_lb (
         .clk    (clk),
         .wr_en  (accept),
         .addr   (col),
         .wr_dat (wr_dat),
         .rd_dat (lb_rd[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
               win[i][j] <= '0;
            end
         end
      end else if (accept) begin
         for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE - 1; j++) begin
               win[i][j] <= win[i][j+1];
            end
         end
         for (int i = 0; i < KSIZE - 1; i++) begin
            win[i][KSIZE-1] <= lb_rd[i];
         end
         win[KSIZE-1][KSIZE-1] <= in_pixel;
      end
   end

   // A stalled window blocks accepts, so the window register doubles as the output data
   always_comb begin
      out_window = '0;
      for (int i = 0; i < KSIZE; i++) begin
         for (int j = 0; j < KSIZE; j++) begin
            out_window[win_lsb(i, j, bitwidth) +: bitwidth] = win[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
      end else if (emit) begin
         out_valid <= 1'b1;
         out_row   <= row - ROW_FIRST;
         out_col   <= col - COL_FIRST;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed-plus-random bench for conv_window_buffer on an 8x8 map, checked against an image-array model.
module tb_conv_window_buffer;

   localparam int BW = 32;
   localparam int MW = 8;
   localparam int MH = 8;
   localparam int K  = 5;
   localparam int WW = K * K * BW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [BW-1:0] in_pixel = '0;
   logic          in_ready;
   logic          out_valid;
   logic          frame_done;
   logic [WW-1:0] out_window;
   logic [2:0]    out_row;
   logic [2:0]    out_col;

   conv_window_buffer #(
      .bitwidth (BW),
      .MAP_W    (MW),
      .MAP_H    (MH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_window (out_window),
      .out_row    (out_row),
      .out_col    (out_col),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] win;
      int            r;
      int            c;
   } exp_t;

   exp_t          q[$];
   logic [BW-1:0] img [MH][MW];
   int            mr, mc;
   int            n_cmp, n_err;
   int            win_cnt, fd_cnt;
   logic [WW-1:0] first_w, last_w, w16, w13;
   int            first_r, first_c, last_r, last_c;
   logic          bp_on, sum_mode;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [BW-1:0] el(input logic [WW-1:0] w, input int i, input int j);
      return w[(i*K+j)*BW +: BW];
   endfunction

   task automatic clear_stats();
      win_cnt = 0;
      fd_cnt  = 0;
      first_w = 'x;
      last_w  = 'x;
      w16     = 'x;
      w13     = 'x;
      first_r = -1;
      first_c = -1;
      last_r  = -1;
      last_c  = -1;
   endtask

   // One clock: drive, check at negedge, update the model, return after the next posedge
   task automatic cycle(input logic v, input logic [BW-1:0] pix, input logic ordy, output logic acc);
      exp_t e;
      logic exp_fd;
      int   s;
      in_valid  = v;
      in_pixel  = pix;
      out_ready = ordy;
      @(negedge clk);
      chk("valid_vs_model", out_valid, q.size() != 0);
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      exp_fd = 1'b0;
      if (out_valid && q.size() != 0) begin
         e = q[0];
         chk("out_window", out_window, e.win);
         chk("out_row", out_row, e.r);
         chk("out_col", out_col, e.c);
         if (out_ready) begin
            e = q.pop_front();
            exp_fd = (e.r == MH - K) && (e.c == MW - K);
            if (win_cnt == 0) begin
               first_w = out_window;
               first_r = out_row;
               first_c = out_col;
            end
            if (win_cnt == 16) w16 = out_window;
            if (e.r == 1 && e.c == 3) w13 = out_window;
            last_w = out_window;
            last_r = out_row;
            last_c = out_col;
            win_cnt++;
            if (sum_mode) begin
               s = 0;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++)
                     s += el(out_window, i, j);
               chk("window_sum", s, 50);
            end
         end
      end
      if (frame_done) fd_cnt++;
      chk("frame_done", frame_done, exp_fd);
      if (bp_on) chk("bp_in_ready", in_ready, 1'b0);
      acc = in_valid && in_ready;
      if (acc) begin
         img[mr][mc] = pix;
         if (mr >= K - 1 && mc >= K - 1) begin
            e.win = '0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  e.win[(i*K+j)*BW +: BW] = img[mr-(K-1)+i][mc-(K-1)+j];
            e.r = mr - (K - 1);
            e.c = mc - (K - 1);
            q.push_back(e);
         end
         mc++;
         if (mc == MW) begin
            mc = 0;
            mr++;
            if (mr == MH) mr = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // mode 0: streaming, 1: random bubbles/stalls, 2: 3-cycle stall on window (1,2), 3: all pixels = 2
   task automatic run_frame(input int base, input int mode, input int npix);
      int            idx;
      int            guard;
      int            hold;
      logic          v, ordy, acc;
      logic [BW-1:0] pix;
      idx = 0;
      guard = 0;
      hold = 0;
      while (idx < npix && guard < 2000) begin
         pix  = (mode == 3) ? BW'(2) : BW'(base + idx);
         v    = 1'b1;
         ordy = 1'b1;
         if (mode == 1) begin
            v    = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
         end
         bp_on = 1'b0;
         if (mode == 2 && out_valid && out_row == 3'd1 && out_col == 3'd2 && hold < 3) begin
            ordy  = 1'b0;
            bp_on = 1'b1;
            hold++;
         end
         cycle(v, v ? pix : BW'($urandom), ordy, acc);
         if (acc) idx++;
         guard++;
      end
      bp_on = 1'b0;
      chk("frame_budget", idx, npix);
      if (mode == 2) chk("bp_hold_cycles", hold, 3);
   endtask

   task automatic flush();
      int   g;
      logic acc;
      g = 0;
      while (q.size() != 0 && g < 20) begin
         cycle(1'b0, '0, 1'b1, acc);
         g++;
      end
      cycle(1'b0, '0, 1'b1, acc);
      chk("flush_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      mr = 0;
      mc = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_window", out_window, '0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_col", out_col, 0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_release_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      mr       = 0;
      mc       = 0;
      bp_on    = 1'b0;
      sum_mode = 1'b0;
      clear_stats();
      do_reset();

      // Basic windowing, pixel = r*8+c
      clear_stats();
      run_frame(0, 0, 64);
      flush();
      chk("basic_win_cnt", win_cnt, 16);
      chk("basic_fd_cnt", fd_cnt, 1);
      chk("first_00", el(first_w, 0, 0), 0);
      chk("first_04", el(first_w, 0, 4), 4);
      chk("first_40", el(first_w, 4, 0), 32);
      chk("first_44", el(first_w, 4, 4), 36);
      chk("first_row", first_r, 0);
      chk("first_col", first_c, 0);
      chk("last_44", el(last_w, 4, 4), 63);
      chk("last_row", last_r, 3);
      chk("last_col", last_c, 3);

      // Constant map: every element 2, all-ones kernel sum 50
      clear_stats();
      sum_mode = 1'b1;
      run_frame(0, 3, 64);
      flush();
      sum_mode = 1'b0;
      chk("const_win_cnt", win_cnt, 16);

      // Backpressure on window (1,2)
      clear_stats();
      run_frame(0, 2, 64);
      flush();
      chk("bp_win_cnt", win_cnt, 16);
      chk("bp_next_44", el(w13, 4, 4), 47);

      // Random bubbles and stalls over two frames
      clear_stats();
      run_frame(1000, 1, 64);
      run_frame(2000, 1, 64);
      flush();
      chk("rand_win_cnt", win_cnt, 32);
      chk("rand_fd_cnt", fd_cnt, 2);

      // Reset after pixel 45, then a fresh frame
      run_frame(0, 0, 46);
      do_reset();
      clear_stats();
      run_frame(0, 0, 64);
      flush();
      chk("rstmid_win_cnt", win_cnt, 16);
      chk("rstmid_first_row", first_r, 0);
      chk("rstmid_first_col", first_c, 0);
      chk("rstmid_first_44", el(first_w, 4, 4), 36);

      // Back-to-back frames, second offset by 100
      clear_stats();
      run_frame(0, 0, 64);
      run_frame(100, 0, 64);
      flush();
      chk("b2b_win_cnt", win_cnt, 32);
      chk("b2b_fd_cnt", fd_cnt, 2);
      chk("b2b_f2_00", el(w16, 0, 0), 100);
      chk("b2b_f2_44", el(w16, 4, 4), 136);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
